// File: rtl/renkon_ctrl_delay.sv
// Control-sideband delay line: start/valid/stop travel through a DEPTH-stage
// pipeline alongside the datapath, with frame tracking, beat counting and protocol checks.
module renkon_ctrl_delay #(
    parameter int DEPTH  = 3,
    parameter int OE_TAP = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_start,
    input  logic             in_valid,
    input  logic             in_stop,
    output logic             out_start,
    output logic             out_valid,
    output logic             out_stop,
    output logic             oe,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             proto_err
);

    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("renkon_ctrl_delay: DEPTH must be in 2..16");
    end
    if (OE_TAP < 0 || OE_TAP > DEPTH - 1) begin : g_bad_tap
        $error("renkon_ctrl_delay: OE_TAP must be in 0..DEPTH-1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_start;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_stop;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_proto_err;
    logic             w_adv;
    logic             w_viol;

    // Handshake: a beat is accepted only on a cycle where adv is high; stalled
    // or flushed inputs are dropped, never queued.
    assign w_adv = !stall && !flush;

    // Illegal: start mid-frame, orphan valid/stop outside a frame, start/stop without data.
    assign w_viol = (in_start && (r_state == S_RUN))
                 || ((in_valid || in_stop) && (r_state == S_IDLE) && !in_start)
                 || ((in_start || in_stop) && !in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_adv) begin
            case (r_state)
                S_IDLE:  if (in_start && !in_stop) w_state_nxt = S_RUN;
                S_RUN:   if (in_stop) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_RUN) || (|r_start) || (|r_valid) || (|r_stop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_start <= '0;
            r_valid <= '0;
            r_stop  <= '0;
        end else if (w_adv) begin
            r_start <= {r_start[DEPTH-2:0], in_start};
            r_valid <= {r_valid[DEPTH-2:0], in_valid};
            r_stop  <= {r_stop[DEPTH-2:0], in_stop};
        end
    end

    // Counter survives flush so software can still read the last frame length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_adv) begin
            if (in_start) begin
                r_beat_cnt <= {{(CNT_W-1){1'b0}}, in_valid};
            end else if ((r_state == S_RUN) && in_valid && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_proto_err <= 1'b0;
        end else if (w_adv && w_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign out_start = r_start[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign out_stop  = r_stop[DEPTH-1];
    assign oe        = r_valid[OE_TAP];
    assign beat_cnt  = r_beat_cnt;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_renkon_ctrl_delay.sv
// Directed bench for renkon_ctrl_delay: vector table plus hand-written
// saturation and mid-frame reset sequences.
module tb_renkon_ctrl_delay;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_start;
    logic        in_valid;
    logic        in_stop;
    logic        out_start;
    logic        out_valid;
    logic        out_stop;
    logic        oe;
    logic        busy;
    logic [15:0] beat_cnt;
    logic        proto_err;

    logic        s_out_start;
    logic        s_out_valid;
    logic        s_out_stop;
    logic        s_oe;
    logic        s_busy;
    logic [2:0]  s_beat_cnt;
    logic        s_proto_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        st;
        logic        v;
        logic        sp;
        logic        stl;
        logic        fl;
        logic [4:0]  exp_o;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    renkon_ctrl_delay #(.DEPTH(3), .OE_TAP(1), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_stop   (in_stop),
        .out_start (out_start),
        .out_valid (out_valid),
        .out_stop  (out_stop),
        .oe        (oe),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .proto_err (proto_err)
    );

    renkon_ctrl_delay #(.DEPTH(3), .OE_TAP(1), .CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_stop   (in_stop),
        .out_start (s_out_start),
        .out_valid (s_out_valid),
        .out_stop  (s_out_stop),
        .oe        (s_oe),
        .busy      (s_busy),
        .beat_cnt  (s_beat_cnt),
        .proto_err (s_proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic sp,
                         input logic stl, input logic fl);
        in_start = st;
        in_valid = v;
        in_stop  = sp;
        stall    = stl;
        flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs are {out_start, out_valid, out_stop, oe, busy} for the cycle after the inputs.
    task automatic add(input logic st, input logic v, input logic sp, input logic stl,
                       input logic fl, input logic [4:0] eo, input int cnt, input logic err);
        vec_t t;
        t.st      = st;
        t.v       = v;
        t.sp      = sp;
        t.stl     = stl;
        t.fl      = fl;
        t.exp_o   = eo;
        t.exp_cnt = 16'(cnt);
        t.exp_err = err;
        tbl.push_back(t);
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].sp, tbl[i].stl, tbl[i].fl);
            step();
            check($sformatf("%s_row%0d_ctl", tag, i),
                  {26'd0, out_start, out_valid, out_stop, oe, busy, proto_err},
                  {26'd0, tbl[i].exp_o, tbl[i].exp_err});
            check($sformatf("%s_row%0d_cnt", tag, i), {16'd0, beat_cnt}, {16'd0, tbl[i].exp_cnt});
        end
    endtask

    initial begin
        int seg_a_hi;
        int seg_end;

        // Frame of 4 beats, no stall
        add(1,1,0,0,0, 5'b00001, 1, 0);
        add(0,1,0,0,0, 5'b00011, 2, 0);
        add(0,1,0,0,0, 5'b11011, 3, 0);
        add(0,1,1,0,0, 5'b01011, 4, 0);
        add(0,0,0,0,0, 5'b01011, 4, 0);
        add(0,0,0,0,0, 5'b01101, 4, 0);
        add(0,0,0,0,0, 5'b00000, 4, 0);
        seg_a_hi = tbl.size() - 1;
        // Same frame with two stall cycles after the start beat
        add(1,1,0,0,0, 5'b00001, 1, 0);
        add(0,1,0,1,0, 5'b00001, 1, 0);
        add(0,1,0,1,0, 5'b00001, 1, 0);
        add(0,1,0,0,0, 5'b00011, 2, 0);
        add(0,1,0,0,0, 5'b11011, 3, 0);
        add(0,1,1,0,0, 5'b01011, 4, 0);
        add(0,0,0,0,0, 5'b01011, 4, 0);
        add(0,0,0,0,0, 5'b01101, 4, 0);
        add(0,0,0,0,0, 5'b00000, 4, 0);
        // Single-beat frame
        add(1,1,1,0,0, 5'b00001, 1, 0);
        add(0,0,0,0,0, 5'b00011, 1, 0);
        add(0,0,0,0,0, 5'b11101, 1, 0);
        add(0,0,0,0,0, 5'b00000, 1, 0);
        // Orphan valid, then a frame killed by flush while stalled
        add(0,1,0,0,0, 5'b00001, 1, 1);
        add(1,1,0,0,0, 5'b00011, 1, 1);
        add(0,1,0,1,1, 5'b00000, 1, 0);
        add(0,0,0,0,0, 5'b00000, 1, 0);
        // Start while RUN
        add(1,1,0,0,0, 5'b00001, 1, 0);
        add(1,1,0,0,0, 5'b00011, 1, 1);
        add(0,0,0,0,1, 5'b00000, 1, 0);
        // Stop without valid
        add(1,1,0,0,0, 5'b00001, 1, 0);
        add(0,0,1,0,0, 5'b00011, 1, 1);
        add(0,0,0,0,1, 5'b00000, 1, 0);
        // Stalled inputs are dropped entirely
        add(0,1,1,1,0, 5'b00000, 1, 0);
        add(1,1,0,1,0, 5'b00000, 1, 0);
        add(0,0,0,0,0, 5'b00000, 1, 0);
        seg_end = tbl.size() - 1;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ctl", {26'd0, out_start, out_valid, out_stop, oe, busy, proto_err}, 32'd0);
        check("reset_cnt", {16'd0, beat_cnt}, 32'd0);

        run_rows(0, seg_end, "tbl");

        // Saturation: 10-beat frame, 3-bit counter sticks at 7
        for (int k = 1; k <= 10; k++) begin
            drive(k == 1, 1, k == 10, 0, 0);
            step();
            check($sformatf("sat_beat%0d_wide", k), {16'd0, beat_cnt}, k);
            check($sformatf("sat_beat%0d_narrow", k), {29'd0, s_beat_cnt}, (k > 7) ? 7 : k);
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) step();
        check("sat_idle_busy", {30'd0, busy, s_busy}, 32'd0);
        check("sat_err", {30'd0, proto_err, s_proto_err}, 32'd0);
        check("sat_final_narrow", {29'd0, s_beat_cnt}, 32'd7);

        // Reset mid-frame, asserted together with stall and flush
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0);
        step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        drive(0, 1, 0, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ctl", {26'd0, out_start, out_valid, out_stop, oe, busy, proto_err}, 32'd0);
        check("mid_rst_cnt", {16'd0, beat_cnt}, 32'd0);
        check("mid_rst_sat", {26'd0, s_out_start, s_out_valid, s_out_stop, s_oe, s_busy, s_proto_err}, 32'd0);
        drive(0, 0, 0, 0, 0);
        step();
        check("post_rst_quiet", {26'd0, out_start, out_valid, out_stop, oe, busy, proto_err}, 32'd0);
        run_rows(0, seg_a_hi, "rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/renkon_ctrl_delay.md
RENKON_CTRL_DELAY -- requirements
Module: renkon_ctrl_delay

Interface
REQ-001 Parameter DEPTH, default 3: pipeline stages for start/valid/stop; legal range 2..16.
REQ-002 Parameter OE_TAP, default 1: stage index (0-based) that drives oe; legal range 0..DEPTH-1.
REQ-003 Parameter CNT_W, default 16: width of beat_cnt.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  hold all pipeline state; inputs ignored while high.
REQ-007 flush  in  1  discard in-flight control; overrides stall.
REQ-008 in_start  in  1  frame start, coincides with the first valid beat.
REQ-009 in_valid  in  1  data beat valid.
REQ-010 in_stop  in  1  frame end, coincides with the last valid beat.
REQ-011 out_start / out_valid / out_stop  out  1 each  stage DEPTH-1 contents.
REQ-012 oe  out  1  valid bit of stage OE_TAP (datapath output-enable).
REQ-013 busy  out  1  frame open or any stage bit set.
REQ-014 beat_cnt  out  CNT_W  accepted valid beats in current/last frame.
REQ-015 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-016 Advance condition: adv = !stall && !flush; when adv, stage0 <= {in_start,in_valid,in_stop} and stage i <= stage i-1 for i = 1..DEPTH-1.
REQ-017 Stall, no flush: every stage, FSM, beat_cnt and proto_err hold; inputs that cycle are dropped, not queued.
REQ-018 Flush, regardless of stall: all stage bits cleared next cycle, FSM to IDLE, proto_err cleared, beat_cnt holds.
REQ-019 Latency: with stall low, an input on cycle N appears on out_* at cycle N+DEPTH; each stall cycle adds one cycle.
REQ-020 oe = stage[OE_TAP].valid; with OE_TAP = DEPTH-2, oe leads out_valid by exactly one cycle.
REQ-021 FSM states IDLE, RUN; sampled only when adv.
REQ-022 IDLE -> RUN on in_start && !in_stop; IDLE stays IDLE on in_start && in_stop (single-beat frame).
REQ-023 RUN -> IDLE on in_stop; RUN stays RUN otherwise.
REQ-024 beat_cnt: on accepted in_start it loads in_valid (0 or 1); in RUN each accepted in_valid increments it; saturates at 2^CNT_W-1, no wrap.
REQ-025 proto_err set on accepted: in_start while RUN; in_valid or in_stop while IDLE without in_start; in_start or in_stop without in_valid.
REQ-026 Illegal beats are still propagated through the pipeline unchanged; only proto_err records them.
REQ-027 busy = (state == RUN) || OR of all stage bits; combinational from registers.
REQ-028 Only out_*, oe, busy, beat_cnt and proto_err are outputs; no combinational path from any input to any output.

Reset
REQ-029 When rst is high at a clock edge: all stage bits 0, FSM IDLE, beat_cnt 0, proto_err 0; hence out_start, out_valid, out_stop, oe and busy 0 the cycle after.
REQ-030 rst overrides flush and stall; rst mid-frame discards the frame with no out_stop emitted.

Verification
REQ-031 DEPTH=3, OE_TAP=1; start+valid at cycle 0, valid cycles 1-2, stop+valid cycle 3 -> out_start at cycle 3, out_valid cycles 3-6, out_stop cycle 6, oe cycles 2-5, beat_cnt=4, proto_err=0.
REQ-032 Same frame, stall high at cycles 1-2 (inputs held) -> out_stop at cycle 8, out_valid 4 beats, no duplicated or lost bits.
REQ-033 start+valid+stop in one cycle at 0 -> FSM stays IDLE, out_start=out_stop=out_valid=1 at cycle 3, beat_cnt=1, busy high cycles 1-3.
REQ-034 in_valid in IDLE without start -> proto_err 1 next cycle and stays 1; flush -> proto_err 0, all out_* 0 next cycle.
REQ-035 CNT_W=3; frame of 10 valid beats -> beat_cnt saturates at 7.
REQ-036 rst during cycle 2 of a RUN frame with bits in flight -> all outputs 0 next cycle, following fresh frame behaves as REQ-031.
